// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a 1 KB bus page with TXDATA/STATUS/DIVISOR/CTRL,
// a small byte FIFO and a serialiser with a programmable bit period of DIVISOR+1 clocks.
module uart_tx_mmio #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433,
    parameter logic [21:0] BASE_PAGE  = 22'd2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] data_addr,
    input  logic [3:0]  datamem_wr,
    input  logic [7:0]  data_wr0,
    input  logic [7:0]  data_wr1,
    input  logic [7:0]  data_wr2,
    input  logic [7:0]  data_wr3,
    output logic [31:0] data_rd,
    output logic        uart_tx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          sel;
    logic          wr_txdata, wr_status, wr_ctrl, wr_div_lo, wr_div_hi;
    logic          push_ok, pop;
    logic          full, empty, busy, baud_done;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          ovf, tx_en, irq_en;
    logic [15:0]   divisor;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [15:0]   baud_cnt;
    logic [7:0]    shifter;
    logic          unused_ok;

    assign unused_ok = ^{data_addr[9:4], data_addr[1:0], datamem_wr[3:2], data_wr2, data_wr3};

    assign sel       = (data_addr[31:10] == BASE_PAGE);
    assign wr_txdata = sel && datamem_wr[0] && (data_addr[3:2] == 2'd0);
    assign wr_status = sel && datamem_wr[0] && (data_addr[3:2] == 2'd1);
    assign wr_div_lo = sel && datamem_wr[0] && (data_addr[3:2] == 2'd2);
    assign wr_div_hi = sel && datamem_wr[1] && (data_addr[3:2] == 2'd2);
    assign wr_ctrl   = sel && datamem_wr[0] && (data_addr[3:2] == 2'd3);

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != IDLE);
    assign baud_done = (baud_cnt == 16'd0);

    // A full FIFO drops the push even when the serialiser pops in the same cycle.
    assign push_ok = wr_txdata && !full;
    assign pop     = tx_en && !empty && ((state == IDLE) || (state == STOP && baud_done));

    assign irq = irq_en && empty && !busy;

    // NOTE: the FIFO storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_wr0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            divisor <= DIV_RESET;
            tx_en   <= 1'b1;
            irq_en  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_status && data_wr0[3]) ovf <= 1'b0;
            if (wr_txdata && full)        ovf <= 1'b1;
            if (wr_div_lo) divisor[7:0]  <= data_wr0;
            if (wr_div_hi) divisor[15:8] <= data_wr1;
            if (wr_ctrl) begin
                tx_en  <= data_wr0[0];
                irq_en <= data_wr0[1];
            end
        end
    end

    // baud_cnt reloads from the live divisor at every bit boundary.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            bit_cnt  <= 3'd0;
            baud_cnt <= 16'd0;
            shifter  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shifter  <= mem[rd_ptr];
                        baud_cnt <= divisor;
                        uart_tx  <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        uart_tx  <= shifter[0];
                        bit_cnt  <= 3'd0;
                        baud_cnt <= divisor;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= divisor;
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            shifter <= shifter >> 1;
                            uart_tx <= shifter[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        if (pop) begin
                            shifter  <= mem[rd_ptr];
                            baud_cnt <= divisor;
                            uart_tx  <= 1'b0;
                            state    <= START;
                        end else begin
                            uart_tx <= 1'b1;
                            state   <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every path assigns data_rd, so no latch is inferred.
    always_comb begin
        data_rd = 32'd0;
        if (sel) begin
            case (data_addr[3:2])
                2'd1:    data_rd = {24'd0, 4'(count), ovf, busy, empty, full};
                2'd2:    data_rd = {16'd0, divisor};
                2'd3:    data_rd = {30'd0, irq_en, tx_en};
                default: data_rd = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus of the FPGA top level, next to the RAM and the GPIO byte register. It decodes its own 1 KB page, buffers CPU byte writes in a small FIFO, and serialises them as 8N1 frames on `uart_tx` at a programmable bit rate. A status/control register set lets firmware poll occupancy or take an interrupt.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two, ≥ 2.
- `DIV_RESET`, 16'd433: reset value of DIVISOR; bit period is DIVISOR+1 clocks.
- `BASE_PAGE`, 22'd2: block is selected when `data_addr[31:10] == BASE_PAGE`.
- `clk` in 1: system clock; single clock domain.
- `rstn` in 1: reset; synchronous, active-low.
- `data_addr` in 32: CPU data address; `[3:2]` selects the register.
- `datamem_wr` in 4: per-byte-lane write strobes; lane i carries `data_wri`.
- `data_wr0`, `data_wr1`, `data_wr2`, `data_wr3` in 8 each: write data, byte lanes 0–3.
- `data_rd` out 32: read data; 0 when not selected.
- `uart_tx` out 1: serial line, idle high, registered.
- `irq` out 1: TX-drained interrupt, level.

## Operation
- Select `sel = (data_addr[31:10] == BASE_PAGE)`; writes act only when `sel` and the relevant strobe is set.
- Offset 0x0 TXDATA: `datamem_wr[0]` pushes `data_wr0`. Push while full is dropped and sets sticky `ovf`. Reads 0.
- Offset 0x4 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 ovf, bits[7:4] FIFO count, others 0. Write lane 0 with `data_wr0[3]=1` clears `ovf`; all other bits ignored.
- Offset 0x8 DIVISOR: bits[15:0], lane 0 writes [7:0], lane 1 writes [15:8]; lanes 2/3 ignored; reads zero-extended.
- Offset 0xC CTRL: bit0 `tx_en` (reset 1), bit1 `irq_en` (reset 0); lane 0 only.
- `data_rd` is combinational from `sel`, `data_addr[3:2]` and register state.
- FIFO: full/empty/count come from the pre-edge count. A push while full is dropped even if a pop occurs the same cycle. A push while empty is accepted; no pop that cycle. Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, START, DATA, STOP; a bit counter 0–7 and a down-counter `baud_cnt`.
- IDLE: `uart_tx=1`. If `tx_en` and not empty, pop into the shifter, load `baud_cnt=DIVISOR`, go to START.
- START: `uart_tx=0`. When `baud_cnt==0`, go to DATA with bit 0; otherwise decrement.
- DATA: `uart_tx=shifter[0]`, LSB first. At each bit end, shift and reload `baud_cnt`; after bit 7, go to STOP.
- STOP: `uart_tx=1`. At the end of STOP, if `tx_en` and not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- `baud_cnt` reloads from the live DIVISOR at every bit boundary, so a DIVISOR write takes effect at the next bit. DIVISOR=0 gives 1 clock per bit.
- Clearing `tx_en` mid-frame lets the current frame complete; no further pops.
- `irq = irq_en & empty & ~busy`.

## Timing
- Reset, sampled at an edge with `rstn=0`: FIFO empty, pointers 0, `ovf=0`, DIVISOR=DIV_RESET, `tx_en=1`, `irq_en=0`, state IDLE, `uart_tx=1`, `irq=0`. Reset mid-frame aborts the frame; `uart_tx` is high after that edge.
- A write in cycle N updates the FIFO at edge E(N). With the FSM idle and `tx_en=1`, the pop occurs at E(N+1) and `uart_tx` is low from E(N+1).
- Frame length is 10·(DIVISOR+1) clocks; back-to-back frames are contiguous.
- Status reads reflect the state after the most recent edge.

## Test plan
- Reset, then read all registers → STATUS=0x02, DIVISOR=433, CTRL=0x1; `uart_tx=1`, `irq=0`.
- DIVISOR=3, write 0xA5 to TXDATA → `uart_tx` low 1 cycle after the write edge. Then 4-cycle bits: 0,1,0,1,0,0,1,0,1,1. Busy clears after 40 cycles.
- DIVISOR=0, push 0x00 and 0xFF back-to-back → 20 contiguous cycles 0,0×8,1,0,1×8,1 with no gap.
- `tx_en=0`, push 9 bytes → after 8 pushes STATUS shows full with count 8. The 9th push sets `ovf`, FIFO unchanged. Writing STATUS with 0x08 clears `ovf`.
- Full FIFO, a push in the same cycle as the FSM pop → push dropped, count 7, `ovf=1`.
- `irq_en=1`, send one byte → `irq=0` while busy, `irq=1` the cycle after STOP ends. Assert `rstn=0` mid-DATA on a second frame → `uart_tx=1`, state IDLE and FIFO empty after that edge.
